uart_cmd_decoder: RTL
=====================

# uart_cmd_decoder

Byte-stream command decoder directly downstream of the UART receiver stage. It consumes the receiver's single-cycle byte-done strobe and 8-bit data, frames 4-byte packets (sync, address, data, checksum), and presents validated register-write commands to the control logic. Checksum failures and stalled packets produce an error strobe with a cause code, and the decoder always recovers to hunting for sync.

## Interface
- SYNC_BYTE, 8'hA5, packet start marker.
- TIMEOUT_CYCLES, 50000, number of consecutive clk cycles without a byte, mid-packet, before the packet is abandoned; 2 ms at 25 MHz; legal range 2..65535.
- clk  in  1  system clock, the same clock as the UART receiver.
- reset  in  1  asynchronous, active-high.
- rx_done_tick  in  1  one-clk strobe; rx_data is valid in the same cycle.
- rx_data  in  8  received byte.
- cmd_valid  out  1  one-clk strobe: cmd_addr/cmd_data hold a new validated command.
- cmd_addr  out  8  address of the last valid command; holds until the next one.
- cmd_data  out  8  data of the last valid command; holds until the next one.
- cmd_err  out  1  one-clk strobe: the packet was discarded.
- err_code  out  2  cause of the last error: 2'b01 checksum, 2'b10 timeout; holds until the next error.
- busy  out  1  high whenever state != IDLE.

## Operation
- Reset: all outputs are 0, state is IDLE, the timeout counter is 0, and the internal addr/data holding registers are 0.
- State machine: IDLE -> ADDR -> DATA -> CHK -> IDLE. All transitions occur only on cycles where rx_done_tick=1, except the timeout transition.
- IDLE: a byte equal to SYNC_BYTE moves the FSM to ADDR. Any other byte is silently dropped: no error, no state change.
- ADDR: the byte is latched as the pending address; next state is DATA.
- DATA: the byte is latched as the pending data; next state is CHK.
- CHK: the expected checksum is (pending_addr + pending_data) mod 256, an 8-bit wrap-around sum.
  - On a match, cmd_addr and cmd_data are loaded with the pending values and cmd_valid pulses.
  - On a mismatch, cmd_err pulses and err_code is set to 01; cmd_addr and cmd_data are unchanged.
  - Either way, the next state is IDLE.
- No resync inside a packet: a byte equal to SYNC_BYTE received in ADDR, DATA or CHK is treated as ordinary payload.
- Timeout counter (16 bits):
  - Cleared on every cycle with rx_done_tick=1, and whenever state = IDLE.
  - Otherwise increments by 1 per clk.
  - When the counter equals TIMEOUT_CYCLES-1 and rx_done_tick=0, the FSM returns to IDLE, cmd_err pulses and err_code is set to 10. The pending registers are left as-is.
- Timeout and byte in the same cycle: the byte wins. It is processed normally and the counter clears.
- Back-to-back packets: a SYNC byte may arrive on the first tick after the CHK byte with no gap required.
- Reset mid-packet returns the block to the reset state immediately. Partial packets are lost and no strobe is emitted.

## Timing
- Output latency: cmd_valid, cmd_err, err_code, cmd_addr and cmd_data are all registered. They change on the clk edge following the edge that samples the CHK-byte rx_done_tick, or the timeout condition.
- Strobe width: cmd_valid and cmd_err are exactly 1 clk wide and never high in the same cycle.
- busy: rises one clk after the SYNC tick is sampled. It falls on the same edge that produces the cmd_valid or cmd_err strobe.
- Input rate: rx_done_tick may assert on consecutive clk cycles, and every tick is consumed. There is no backpressure; the consumer must accept cmd_valid in the cycle it is asserted.
- Timeout duration: with the last byte tick sampled at edge N, the timeout strobe appears at edge N+TIMEOUT_CYCLES+1.

## Test plan
- Valid packet: bytes A5,10,22,32 delivered with ticks 163 clk apart -> one cmd_valid pulse, cmd_addr=0x10, cmd_data=0x22, busy low afterwards, cmd_err never asserted.
- Checksum wrap and mismatch:
  - A5,F0,20,10 -> cmd_valid with addr F0, data 20.
  - Then A5,01,02,04 -> cmd_err pulse, err_code=01, cmd_addr/cmd_data still F0/20.
- Garbage and in-packet sync:
  - 00,FF,5A before A5,A5,A5,4A -> the leading bytes are ignored.
  - The packet then decodes as addr A5, data A5, checksum 4A valid -> cmd_valid.
- Timeout (TIMEOUT_CYCLES=100):
  - A5,33 then silence -> cmd_err with err_code=10 exactly 101 edges after the 33 tick; busy drops.
  - A following A5,01,01,02 decodes normally.
- Timeout/byte race (TIMEOUT_CYCLES=100): deliver the DATA tick on exactly the cycle the counter reaches 99 -> no error, and the packet completes after the CHK byte.
- Reset mid-packet: assert reset after A5,44 -> all outputs 0 immediately. After release, a full valid packet 77,88,FF framed by A5 yields cmd_valid with no stale error.

Source files
------------

// File: rtl/uart_cmd_decoder_if.sv
// uart_cmd_decoder_if
// Groups the byte stream from the UART receiver and the decoded command
// outputs of uart_cmd_decoder into one bundle.
//   rx_done_tick : one-clk strobe, rx_data valid in the same cycle
//   rx_data      : received byte
//   cmd_valid    : one-clk strobe, cmd_addr/cmd_data hold a new command
//   cmd_addr     : address of the last valid command
//   cmd_data     : data of the last valid command
//   cmd_err      : one-clk strobe, a packet was discarded
//   err_code     : cause of the last error (01 checksum, 10 timeout)
//   busy         : decoder is inside a packet
// master drives the byte stream and consumes commands; slave is the decoder.
interface uart_cmd_decoder_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       cmd_err;
    logic [1:0] err_code;
    logic       busy;

    modport master (
        output rx_done_tick, rx_data,
        input  cmd_valid, cmd_addr, cmd_data, cmd_err, err_code, busy
    );

    modport slave (
        input  rx_done_tick, rx_data,
        output cmd_valid, cmd_addr, cmd_data, cmd_err, err_code, busy
    );
endinterface

// File: rtl/uart_cmd_decoder.sv
// uart_cmd_decoder
// Frames 4-byte packets (sync, address, data, checksum) out of the UART
// receiver byte stream and presents validated register-write commands.
// Checksum failures and stalled packets pulse cmd_err with a cause code;
// the decoder always falls back to hunting for the sync byte.
// Ports:
//   clk   : system clock (same as the UART receiver)
//   reset : asynchronous, active-high
//   bus   : uart_cmd_decoder_if.slave (byte stream in, commands out)
module uart_cmd_decoder #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input logic               clk,
    input logic               reset,
    uart_cmd_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        CHK
    } state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        tick_q, tick_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] count_q, count_d;
    logic [7:0]  addr_pend_q, addr_pend_d;
    logic [7:0]  data_pend_q, data_pend_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic        cmd_err_q, cmd_err_d;
    logic [7:0]  cmd_addr_q, cmd_addr_d;
    logic [7:0]  cmd_data_q, cmd_data_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [7:0]  chk_sum;
    logic        timeout_hit;

    // All state, including the registered copy of the incoming byte strobe.
    // The input stage gives the FSM and the timeout counter a common view of
    // the tick, so a byte and an expiring counter in the same cycle resolve
    // in favour of the byte, and every output lands one edge after sampling.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= 1'b0;
            byte_q      <= 8'h00;
            count_q     <= 16'h0000;
            addr_pend_q <= 8'h00;
            data_pend_q <= 8'h00;
            cmd_valid_q <= 1'b0;
            cmd_err_q   <= 1'b0;
            cmd_addr_q  <= 8'h00;
            cmd_data_q  <= 8'h00;
            err_code_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            byte_q      <= byte_d;
            count_q     <= count_d;
            addr_pend_q <= addr_pend_d;
            data_pend_q <= data_pend_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_err_q   <= cmd_err_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_data_q  <= cmd_data_d;
            err_code_q  <= err_code_d;
        end
    end

    // Next-state logic: packet framing, checksum compare and the
    // inter-byte timeout. Strobes default low so they last one clk.
    always_comb begin
        state_d     = state_q;
        tick_d      = bus.rx_done_tick;
        byte_d      = bus.rx_data;
        addr_pend_d = addr_pend_q;
        data_pend_d = data_pend_q;
        cmd_valid_d = 1'b0;
        cmd_err_d   = 1'b0;
        cmd_addr_d  = cmd_addr_q;
        cmd_data_d  = cmd_data_q;
        err_code_d  = err_code_q;
        chk_sum     = addr_pend_q + data_pend_q;

        if (tick_q || state_q == IDLE) begin
            count_d = 16'h0000;
        end else begin
            count_d = count_q + 16'd1;
        end

        timeout_hit = (state_q != IDLE) && !tick_q && (count_q == TIMEOUT_LAST);

        if (timeout_hit) begin
            state_d    = IDLE;
            cmd_err_d  = 1'b1;
            err_code_d = 2'b10;
        end else if (tick_q) begin
            // Sync is only recognised in IDLE; inside a packet it is payload.
            case (state_q)
                IDLE: begin
                    if (byte_q == SYNC_BYTE) begin
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    addr_pend_d = byte_q;
                    state_d     = DATA;
                end
                DATA: begin
                    data_pend_d = byte_q;
                    state_d     = CHK;
                end
                CHK: begin
                    if (byte_q == chk_sum) begin
                        cmd_valid_d = 1'b1;
                        cmd_addr_d  = addr_pend_q;
                        cmd_data_d  = data_pend_q;
                    end else begin
                        cmd_err_d  = 1'b1;
                        err_code_d = 2'b01;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_err   = cmd_err_q;
    assign bus.cmd_addr  = cmd_addr_q;
    assign bus.cmd_data  = cmd_data_q;
    assign bus.err_code  = err_code_q;
    assign bus.busy      = (state_q != IDLE);

endmodule
